// File: rtl/dsp_nco_iq.sv
`default_nettype none
// ============================================================================
// Module : dsp_nco_iq
// Brief  : Three-stage quadrature NCO; phase accumulator, quarter-wave folded
//          sine table, registered sin/cos with valid flag.
// Rev    : 1.0
// ============================================================================
module dsp_nco_iq #(
    parameter int                     PHASE_WIDTH = 32,
    parameter int                     ADDR_WIDTH  = 12,
    parameter int                     DATA_WIDTH  = 12,
    parameter logic [PHASE_WIDTH-1:0] FTW_RESET   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   clr,
    input  logic [PHASE_WIDTH-1:0] ftw_in,
    input  logic                   ftw_load,
    input  logic [ADDR_WIDTH-1:0]  phase_off,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  sin_out,
    output logic [DATA_WIDTH-1:0]  cos_out
);

    localparam int                  c_N      = 1 << ADDR_WIDTH;
    localparam int                  c_QW     = ADDR_WIDTH - 2;
    localparam int                  c_AMP    = (1 << (DATA_WIDTH - 1)) - 1;
    localparam real                 c_TWO_PI = 6.28318530717958647692;
    localparam logic [ADDR_WIDTH:0] c_HALF   = (ADDR_WIDTH+1)'(c_N / 2);
    localparam logic [ADDR_WIDTH:0] c_FULL   = (ADDR_WIDTH+1)'(c_N);
    localparam logic [ADDR_WIDTH-1:0] c_QTR  = ADDR_WIDTH'(c_N / 4);

    // Entry k holds round(A*sin(2*pi*(k+1)/N)); index 0 is handled as a zero.
    function automatic logic [DATA_WIDTH-1:0] rom_entry(input int k);
        real r;
        r = real'(c_AMP) * $sin(c_TWO_PI * real'(k + 1) / real'(c_N));
        return DATA_WIDTH'($rtoi(r + 0.5));
    endfunction

    // Returns {neg, idx}; idx spans 0..N/4 inclusive.
    function automatic logic [ADDR_WIDTH+1:0] fold(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] ax;
        logic [ADDR_WIDTH:0] idx;
        logic                neg;
        ax = {1'b0, a};
        case (a[ADDR_WIDTH-1 -: 2])
            2'd0:    begin idx = ax;          neg = 1'b0; end
            2'd1:    begin idx = c_HALF - ax; neg = 1'b0; end
            2'd2:    begin idx = ax - c_HALF; neg = 1'b1; end
            default: begin idx = c_FULL - ax; neg = 1'b1; end
        endcase
        return {neg, idx};
    endfunction

    logic [DATA_WIDTH-1:0] w_rom [c_N/4];

    for (genvar k = 0; k < c_N / 4; k++) begin : g_rom
        assign w_rom[k] = rom_entry(k);
    end

    // Stage 1: accumulator, tuning register, truncated phase
    logic [PHASE_WIDTH-1:0] r_acc_q, w_acc_d;
    logic [PHASE_WIDTH-1:0] r_ftw_q, w_ftw_d;
    logic [ADDR_WIDTH-1:0]  r_p1_q,  w_p1_d;
    logic                   r_v1_q,  w_v1_d;

    always_comb begin
        w_acc_d = r_acc_q;
        w_p1_d  = r_p1_q;
        w_v1_d  = 1'b0;
        w_ftw_d = ftw_load ? ftw_in : r_ftw_q;
        if (clr) begin
            w_acc_d = '0;
        end else if (ce) begin
            w_acc_d = r_acc_q + r_ftw_q;
            w_p1_d  = r_acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase_off;
            w_v1_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q <= '0;
            r_ftw_q <= FTW_RESET;
            r_p1_q  <= '0;
            r_v1_q  <= 1'b0;
        end else begin
            r_acc_q <= w_acc_d;
            r_ftw_q <= w_ftw_d;
            r_p1_q  <= w_p1_d;
            r_v1_q  <= w_v1_d;
        end
    end

    // Stage 2: quadrant fold for both paths; cosine leads by a quarter turn
    logic [ADDR_WIDTH-1:0] w_cos_a;
    logic [ADDR_WIDTH+1:0] w_sin_fold, w_cos_fold;
    logic [ADDR_WIDTH:0]   r_sin_idx_q, r_cos_idx_q;
    logic                  r_sin_neg_q, r_cos_neg_q;
    logic                  r_v2_q;

    assign w_cos_a    = r_p1_q + c_QTR;
    assign w_sin_fold = fold(r_p1_q);
    assign w_cos_fold = fold(w_cos_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin_idx_q <= '0;
            r_cos_idx_q <= '0;
            r_sin_neg_q <= 1'b0;
            r_cos_neg_q <= 1'b0;
            r_v2_q      <= 1'b0;
        end else begin
            r_sin_idx_q <= w_sin_fold[ADDR_WIDTH:0];
            r_cos_idx_q <= w_cos_fold[ADDR_WIDTH:0];
            r_sin_neg_q <= w_sin_fold[ADDR_WIDTH+1];
            r_cos_neg_q <= w_cos_fold[ADDR_WIDTH+1];
            r_v2_q      <= clr ? 1'b0 : r_v1_q;
        end
    end

    // Stage 3: table lookup and sign restore
    logic [c_QW-1:0]       w_sin_addr, w_cos_addr;
    logic [DATA_WIDTH-1:0] w_sin_val,  w_cos_val;
    logic [DATA_WIDTH-1:0] w_sin_d,    w_cos_d;

    assign w_sin_addr = c_QW'(r_sin_idx_q - 1'b1);
    assign w_cos_addr = c_QW'(r_cos_idx_q - 1'b1);
    assign w_sin_val  = (r_sin_idx_q == '0) ? '0 : w_rom[w_sin_addr];
    assign w_cos_val  = (r_cos_idx_q == '0) ? '0 : w_rom[w_cos_addr];
    assign w_sin_d    = r_sin_neg_q ? (DATA_WIDTH'(0) - w_sin_val) : w_sin_val;
    assign w_cos_d    = r_cos_neg_q ? (DATA_WIDTH'(0) - w_cos_val) : w_cos_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            sin_out   <= w_sin_d;
            cos_out   <= w_cos_d;
            out_valid <= clr ? 1'b0 : r_v2_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_nco_iq.sv
`default_nettype none
// ============================================================================
// Module : tb_dsp_nco_iq
// Brief  : Directed scoreboard bench for dsp_nco_iq against a real-valued sine.
// Rev    : 1.0
// ============================================================================
module tb_dsp_nco_iq;

    localparam int c_PW = 32;
    localparam int c_AW = 12;
    localparam int c_DW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce;
    logic            clr;
    logic            ftw_load;
    logic [c_PW-1:0] ftw_in;
    logic [c_AW-1:0] phase_off;
    logic            out_valid;
    logic [c_DW-1:0] sin_out;
    logic [c_DW-1:0] cos_out;

    dsp_nco_iq #(
        .PHASE_WIDTH (c_PW),
        .ADDR_WIDTH  (c_AW),
        .DATA_WIDTH  (c_DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .clr       (clr),
        .ftw_in    (ftw_in),
        .ftw_load  (ftw_load),
        .phase_off (phase_off),
        .out_valid (out_valid),
        .sin_out   (sin_out),
        .cos_out   (cos_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_DW-1:0] s;
        logic [c_DW-1:0] c;
    } samp_t;

    samp_t       sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_ftw = '0;
    logic [2:0]  m_vpipe = '0;

    function automatic logic [c_DW-1:0] golden(input int p);
        real r;
        r = 2047.0 * $sin(6.28318530717958647692 * real'(p % 4096) / 4096.0);
        if (r >= 0.0) return c_DW'($rtoi(r + 0.5));
        return c_DW'(-$rtoi(0.5 - r));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the reference, check after the edge.
    task automatic step(input logic i_ce, input logic i_clr, input logic i_ld,
                        input logic [31:0] i_ftw, input logic [c_AW-1:0] i_off);
        logic  vin;
        int    ph;
        samp_t smp;
        ce = i_ce; clr = i_clr; ftw_load = i_ld; ftw_in = i_ftw; phase_off = i_off;
        vin = 1'b0;
        if (rst_n === 1'b1) begin
            if (i_clr) begin
                if (m_vpipe[0]) void'(sb.pop_back());
                if (m_vpipe[1]) void'(sb.pop_back());
                m_acc = '0;
            end else if (i_ce) begin
                ph    = int'(m_acc[31:20]) + int'(i_off);
                smp.s = golden(ph);
                smp.c = golden(ph + 1024);
                sb.push_back(smp);
                m_acc = m_acc + m_ftw;
                vin   = 1'b1;
            end
            if (i_ld) m_ftw = i_ftw;
            m_vpipe = i_clr ? 3'b000 : {m_vpipe[1:0], vin};
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vpipe[2]));
        if (rst_n !== 1'b1) begin
            chk("rst_sin", 32'(sin_out), 32'(0));
            chk("rst_cos", 32'(cos_out), 32'(0));
        end else if (out_valid === 1'b1 && m_vpipe[2]) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                smp = sb.pop_front();
                chk("sin_out", 32'(sin_out), 32'(smp.s));
                chk("cos_out", 32'(cos_out), 32'(smp.c));
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_acc   = '0;
        m_ftw   = '0;
        m_vpipe = '0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; clr = 1'b0; ftw_load = 1'b0;
        ftw_in = '0; phase_off = '0;

        // Reset held with ce toggling
        for (int i = 0; i < 4; i++) step(1'(i & 1), 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

        // Quarter-step sequence, then quarter-turn phase offset
        step(1'b0, 1'b1, 1'b1, 32'h4000_0000, '0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 1'b0, '0, 12'd1024);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, '0, '0);

        // Half-turn step with ce gaps; accumulator wraps every two samples
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, '0);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            step(1'b0, 1'b0, 1'b0, '0, '0);
            step(1'b1, 1'b0, 1'b0, '0, '0);
            step(1'b1, 1'b0, 1'b0, '0, '0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

        // clr and ftw_load in the same cycle mid-stream
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h2000_0000, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, '0);

        // Asynchronous reset mid-stream, away from a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_valid", 32'(out_valid), 32'(0));
        chk("async_sin",   32'(sin_out),   32'(0));
        chk("async_cos",   32'(cos_out),   32'(0));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 32'h0400_0000, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 12'd77);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

        // Full-period sweep at one address per sample
        step(1'b0, 1'b1, 1'b1, 32'h0010_0000, '0);
        for (int i = 0; i < 4096; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
